irrigation_valve_driver: RTL

- Actuator-side consumer of the fuzzy controller's irrigation_time and rain_present outputs.
- Accepts a watering request through a valid/ready handshake and drives the pump/valve for irrigation_time units, each unit lasting TICKS_PER_UNIT clock cycles.
- Aborts the run on rain or an external abort, then enforces a cooldown before it accepts the next request.
- Sits between the fuzzy inference block and the pump relay output.

---
 rtl/irrigation_valve_driver.sv | 137 +++++++++++++
 1 files changed

// File: rtl/irrigation_valve_driver.sv
`default_nettype none
// ============================================================================
//  Module      : irrigation_valve_driver
//  Description : Takes a watering request over a valid/ready handshake and
//                drives the pump relay for irrigation_time units. A run is
//                aborted by rain or an external abort. Every run is followed
//                by a cooldown lockout.
//  Revision    : 1.0 - initial release
// ============================================================================
module irrigation_valve_driver #(
    parameter int unsigned TICKS_PER_UNIT = 50000000,
    parameter int unsigned COOLDOWN_UNITS = 60,
    parameter int unsigned MAX_TIME       = 60
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  irrigation_time,
    input  logic        rain_present,
    input  logic        abort,
    output logic        pump_on,
    output logic        busy,
    output logic [7:0]  remaining,
    output logic        done,
    output logic        aborted,
    output logic [15:0] run_count
);

    // State encoding
    localparam logic [1:0] c_ST_IDLE     = 2'd0;
    localparam logic [1:0] c_ST_WATER    = 2'd1;
    localparam logic [1:0] c_ST_COOLDOWN = 2'd2;

    // The prescaler needs at least one bit, even when TICKS_PER_UNIT is 1
    localparam int unsigned c_PRE_W = (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;
    localparam logic [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(TICKS_PER_UNIT - 1);

    // Cooldown length in cycles. A length of zero still spends one cycle in COOLDOWN.
    localparam longint unsigned c_COOL_CYC  = longint'(COOLDOWN_UNITS) * longint'(TICKS_PER_UNIT);
    localparam int unsigned     c_COOL_W    = (c_COOL_CYC > 1) ? $clog2(c_COOL_CYC) : 1;
    localparam logic [c_COOL_W-1:0] c_COOL_LAST = (c_COOL_CYC == 0) ? '0 : c_COOL_W'(c_COOL_CYC - 1);

    // Clamp limit, held to 8 bits to match irrigation_time
    localparam logic [7:0] c_MAX_T = (MAX_TIME > 255) ? 8'd255 : 8'(MAX_TIME);

    logic [1:0]          r_state;
    logic [c_PRE_W-1:0]  r_pre;
    logic [c_COOL_W-1:0] r_cool;
    logic [7:0]          w_t;
    logic                w_accept;
    logic                w_stop;

    // Ready only while idle, and never during a reset cycle
    assign req_ready = (r_state == c_ST_IDLE) && !reset;
    assign w_accept  = req_valid && req_ready;
    assign w_stop    = rain_present || abort;
    assign w_t       = (irrigation_time > c_MAX_T) ? c_MAX_T : irrigation_time;

    // Main control FSM with registered outputs and counters
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_ST_IDLE;
            r_pre     <= '0;
            r_cool    <= '0;
            pump_on   <= 1'b0;
            busy      <= 1'b0;
            remaining <= 8'd0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            run_count <= 16'd0;
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        if (w_stop) begin
                            aborted <= 1'b1;
                        end else if (w_t == 8'd0) begin
                            done <= 1'b1;
                        end else begin
                            r_state   <= c_ST_WATER;
                            remaining <= w_t;
                            r_pre     <= '0;
                            pump_on   <= 1'b1;
                            busy      <= 1'b1;
                        end
                    end
                end

                c_ST_WATER: begin
                    if (w_stop) begin
                        // Abort wins over a same-edge completion; remaining freezes
                        r_state <= c_ST_COOLDOWN;
                        r_cool  <= '0;
                        pump_on <= 1'b0;
                        aborted <= 1'b1;
                    end else if (r_pre == c_PRE_LAST) begin
                        r_pre <= '0;
                        if (remaining == 8'd1) begin
                            r_state   <= c_ST_COOLDOWN;
                            r_cool    <= '0;
                            pump_on   <= 1'b0;
                            done      <= 1'b1;
                            remaining <= 8'd0;
                            if (run_count != 16'hFFFF) begin
                                run_count <= run_count + 16'd1;
                            end
                        end else begin
                            remaining <= remaining - 8'd1;
                        end
                    end else begin
                        r_pre <= r_pre + 1'b1;
                    end
                end

                c_ST_COOLDOWN: begin
                    if (r_cool >= c_COOL_LAST) begin
                        r_state <= c_ST_IDLE;
                        busy    <= 1'b0;
                    end else begin
                        r_cool <= r_cool + 1'b1;
                    end
                end

                default: begin
                    r_state <= c_ST_IDLE;
                    pump_on <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
